alu_op_decode_queue: RTL and testbench
======================================

# alu_op_decode_queue

Buffered, parametrised opcode-to-ALU-operation decoder sitting between instruction fetch/decode and the ALU issue stage. Each accepted 8-bit instruction opcode is translated into the ALU operation code, an operand-B immediate select and an instruction class. The result is held in a DEPTH-entry FIFO with valid/ready handshakes on both sides, so fetch and execute can stall independently. It adds flush support and a delivered-operation counter. The ALU operation constants are parametrised.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- ADDU_OP, 8'h06, ALU op issued for JMP (sub 1100/1000) and BCOND
- JLINK_OP, 8'h4F, ALU op issued for JMP sub 1111
- LUI_OP, 8'hF0, ALU op issued for LUI
- clock  in  1  single clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- flush  in  1  discard all queued entries and any same-cycle input
- in_valid  in  1  in_opcode is valid
- in_ready  out  1  block can accept this cycle
- in_opcode  in  8  instruction opcode
- out_valid  out  1  head entry is valid
- out_ready  in  1  consumer takes head entry this cycle
- out_alu_op  out  8  decoded ALU operation of head entry
- out_imm_sel  out  1  operand B comes from immediate
- out_class  out  3  0 RTYPE, 1 JMP, 2 SHIFT, 3 BCOND, 4 LUI, 5 ITYPE
- count  out  $clog2(DEPTH)+1  current occupancy
- op_count  out  16  saturating count of delivered entries

## Operation
- Decode on class field c = in_opcode[7:4], sub field s = in_opcode[3:0]:
  - c=0000, RTYPE: alu_op = opcode; imm_sel 0; class 0
  - c=0100, JMP: s∈{1100,1000} → ADDU_OP, imm_sel 1. s=1111 → JLINK_OP, imm_sel 0. Other s → opcode unmodified, imm_sel 0. Class 1 in all cases.
  - c=1000, SHIFT: alu_op = opcode; imm_sel 0; class 2
  - c=1100, BCOND: ADDU_OP; imm_sel 1; class 3
  - c=1111, LUI: LUI_OP; imm_sel 1; class 4
  - any other c, ITYPE: alu_op = {4'b0000, c}; imm_sel 1; class 5
- Push occurs when in_valid && in_ready && !flush. The decoded triple {alu_op, imm_sel, class} is written at the tail.
- Pop occurs when out_valid && out_ready && !flush. The head pointer advances, and op_count increments, saturating at 16'hFFFF.
- in_ready = (count < DEPTH). A full FIFO does not accept input in the same cycle as a pop; there is no pass-through.
- Simultaneous push and pop with 0<count<DEPTH: count unchanged, both pointers advance.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. count distinguishes full from empty.
- flush: pointers and count go to 0 on the next edge, and the same-cycle push and pop are both ignored. op_count is not affected.
- reset: has priority over flush. Pointers, count and op_count go to 0. Storage contents are don't-care.
- Outputs out_alu_op, out_imm_sel and out_class are valid only while out_valid=1. When empty they hold the value of the last head slot.

## Timing
- Reset values: in_ready=1, out_valid=0, count=0, op_count=0. out_alu_op, out_imm_sel and out_class are don't-care while out_valid=0.
- Latency: an opcode accepted on edge k appears at the head (out_valid=1) after edge k if the FIFO was empty. Otherwise it appears behind the older entries.
- out_valid = (count != 0). in_ready and out_valid are pure functions of registered count, with no combinational path from in_valid or out_ready.
- Throughput: one push and one pop per cycle sustained while 0<count<DEPTH.
- Reset asserted mid-stream: all queued entries are lost on that edge, and the handshakes resume on the first cycle after reset deasserts.

## Test plan
- Decode sweep: push all 256 opcodes with out_ready=1. Expected: 8'h4C→06/imm1/cls1, 8'h48→06/imm1/cls1, 8'h4F→4F/imm0/cls1, 8'h43→43/imm0/cls1, 8'h05→05/imm0/cls0, 8'h87→87/imm0/cls2, 8'hC3→06/imm1/cls3, 8'hF9→F0/imm1/cls4, 8'h2A→02/imm1/cls5. Final op_count=256.
- Fill/backpressure: out_ready=0, push 5 opcodes with DEPTH=4. Expected: in_ready drops after 4th push, count=4, 5th held. Raise out_ready; entries emerge in order and the 5th is accepted the cycle after count<4.
- Wrap and concurrency: random in_valid/out_ready at 50% for 1000 cycles. Scoreboard matches order and decode, and count never exceeds DEPTH.
- Flush: queue 3 entries, then assert flush together with in_valid=1 and out_ready=1. Next cycle: count=0, out_valid=0, the input is dropped and op_count is unchanged.
- Reset mid-operation: count=2 and op_count=7, then reset for one cycle. Expected: count=0, op_count=0, in_ready=1.
- Saturation: force 65537 pops. Expected: op_count holds at 16'hFFFF.

Source files
------------

// File: rtl/alu_op_decode_queue.sv
// Opcode-to-ALU-op decoder feeding a DEPTH-entry valid/ready FIFO.
// Tracks occupancy and a saturating count of delivered operations.
module alu_op_decode_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [7:0]  ADDU_OP  = 8'h06,
  parameter logic [7:0]  JLINK_OP = 8'h4F,
  parameter logic [7:0]  LUI_OP   = 8'hF0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [7:0]                 in_opcode,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [7:0]                 out_alu_op,
  output logic                       out_imm_sel,
  output logic [2:0]                 out_class,
  output logic [$clog2(DEPTH):0]     count,
  output logic [15:0]                op_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [7:0] alu_op;
    logic       imm_sel;
    logic [2:0] cls;
  } dec_t;

  dec_t           dec;
  dec_t           mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [15:0]    op_count_q, op_count_d;
  logic           push, pop;
  logic [3:0]     c, s;

  assign c = in_opcode[7:4];
  assign s = in_opcode[3:0];

  always_comb begin
    dec = '{alu_op: {4'b0000, c}, imm_sel: 1'b1, cls: 3'd5};
    unique case (1'b1)
      (c == 4'h0): dec = '{alu_op: in_opcode, imm_sel: 1'b0, cls: 3'd0};
      (c == 4'h4): begin
        if (s == 4'hC || s == 4'h8)
          dec = '{alu_op: ADDU_OP, imm_sel: 1'b1, cls: 3'd1};
        else if (s == 4'hF)
          dec = '{alu_op: JLINK_OP, imm_sel: 1'b0, cls: 3'd1};
        else
          dec = '{alu_op: in_opcode, imm_sel: 1'b0, cls: 3'd1};
      end
      (c == 4'h8): dec = '{alu_op: in_opcode, imm_sel: 1'b0, cls: 3'd2};
      (c == 4'hC): dec = '{alu_op: ADDU_OP, imm_sel: 1'b1, cls: 3'd3};
      (c == 4'hF): dec = '{alu_op: LUI_OP, imm_sel: 1'b1, cls: 3'd4};
      default:     dec = '{alu_op: {4'b0000, c}, imm_sel: 1'b1, cls: 3'd5};
    endcase
  end

  // Handshakes depend only on registered occupancy.
  assign in_ready  = (count_q < CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  always_comb begin
    wr_ptr_d   = wr_ptr_q + AW'(push);
    rd_ptr_d   = rd_ptr_q + AW'(pop);
    count_d    = count_q + CW'(push) - CW'(pop);
    op_count_d = op_count_q;
    if (pop && op_count_q != 16'hFFFF)
      op_count_d = op_count_q + 16'd1;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      op_count_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      op_count_q <= op_count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push)
      mem_q[wr_ptr_q] <= dec;
  end

  assign out_alu_op  = mem_q[rd_ptr_q].alu_op;
  assign out_imm_sel = mem_q[rd_ptr_q].imm_sel;
  assign out_class   = mem_q[rd_ptr_q].cls;
  assign count       = count_q;
  assign op_count    = op_count_q;

endmodule

// File: tb/tb_alu_op_decode_queue.sv
// Directed bench for alu_op_decode_queue: decode table, backpressure,
// scoreboarded random traffic, flush, mid-stream reset and saturation.
module tb_alu_op_decode_queue;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [7:0]  in_opcode, out_alu_op;
  logic        out_imm_sel;
  logic [2:0]  out_class;
  logic [2:0]  count;
  logic [15:0] op_count;

  int errors = 0;
  int checks = 0;

  alu_op_decode_queue #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_alu_op(out_alu_op), .out_imm_sel(out_imm_sel),
    .out_class(out_class), .count(count), .op_count(op_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [11:0] model(input logic [7:0] op);
    logic [3:0] hi, lo;
    hi = op[7:4];
    lo = op[3:0];
    if (hi == 4'h0) return {op, 1'b0, 3'd0};
    if (hi == 4'h4) begin
      if (lo == 4'hC || lo == 4'h8) return {8'h06, 1'b1, 3'd1};
      if (lo == 4'hF) return {8'h4F, 1'b0, 3'd1};
      return {op, 1'b0, 3'd1};
    end
    if (hi == 4'h8) return {op, 1'b0, 3'd2};
    if (hi == 4'hC) return {8'h06, 1'b1, 3'd3};
    if (hi == 4'hF) return {8'hF0, 1'b1, 3'd4};
    return {4'h0, hi, 1'b1, 3'd5};
  endfunction

  function automatic logic [11:0] head();
    return {out_alu_op, out_imm_sel, out_class};
  endfunction

  // Hand-computed decode vectors: opcode, alu_op, imm_sel, class.
  logic [7:0]  dv_op  [9] = '{8'h4C, 8'h48, 8'h4F, 8'h43, 8'h05,
                              8'h87, 8'hC3, 8'hF9, 8'h2A};
  logic [11:0] dv_exp [9] = '{{8'h06,1'b1,3'd1}, {8'h06,1'b1,3'd1},
                              {8'h4F,1'b0,3'd1}, {8'h43,1'b0,3'd1},
                              {8'h05,1'b0,3'd0}, {8'h87,1'b0,3'd2},
                              {8'h06,1'b1,3'd3}, {8'hF0,1'b1,3'd4},
                              {8'h02,1'b1,3'd5}};
  logic [7:0]  bp_op  [5] = '{8'h05, 8'h87, 8'h43, 8'hC3, 8'h2A};

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0]  q [$];
    logic [15:0] saved;
    logic        exp_push, exp_pop;
    in_opcode = '0;
    do_reset();
    tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_count", count, 0);
    check("rst_op_count", op_count, 0);

    // Directed decode table
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1; in_opcode = dv_op[i];
      tick();
      check($sformatf("vec_%02h_valid", dv_op[i]), out_valid, 1);
      check($sformatf("vec_%02h", dv_op[i]), head(), dv_exp[i]);
    end
    in_valid = 1'b0;
    tick();

    // Full sweep
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      in_valid = 1'b1; in_opcode = 8'(i);
      tick();
      check($sformatf("sweep_%02h", i), head(), model(8'(i)));
    end
    in_valid = 1'b0;
    tick();
    check("sweep_op_count", op_count, 256);
    check("sweep_count", count, 0);

    // Fill and backpressure
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; in_opcode = bp_op[k];
      check($sformatf("bp_in_ready_%0d", k), in_ready, k < 4);
      tick();
    end
    check("bp_full_count", count, 4);
    check("bp_full_ready", in_ready, 0);
    out_ready = 1'b1;
    tick();
    check("bp_count_a", count, 3);
    check("bp_head_1", head(), model(bp_op[1]));
    check("bp_ready_back", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("bp_count_b", count, 3);
    check("bp_head_2", head(), model(bp_op[2]));
    tick();
    check("bp_head_3", head(), model(bp_op[3]));
    tick();
    check("bp_head_4", head(), model(bp_op[4]));
    check("bp_count_c", count, 1);
    tick();
    check("bp_empty", out_valid, 0);

    // Random traffic against a scoreboard
    for (int n = 0; n < 1000; n++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_opcode = 8'($urandom_range(0, 255));
      exp_push  = in_valid && (q.size() < DEPTH);
      exp_pop   = out_ready && (q.size() != 0);
      check("rnd_out_valid", out_valid, q.size() != 0);
      check("rnd_in_ready", in_ready, q.size() < DEPTH);
      if (exp_pop && q.size() != 0) begin
        check("rnd_head", head(), model(q[0]));
        void'(q.pop_front());
      end
      if (exp_push) q.push_back(in_opcode);
      tick();
      check("rnd_count", count, q.size());
      check("rnd_bound", count <= DEPTH, 1);
    end

    // Drain, then flush with a same-cycle push and pop
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 16 && out_valid; i++) tick();
    check("drain_done", out_valid, 0);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_opcode = bp_op[k];
      tick();
    end
    check("fl_pre_count", count, 3);
    saved = op_count;
    flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_opcode = 8'h05;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_count", count, 0);
    check("fl_out_valid", out_valid, 0);
    check("fl_op_count", op_count, saved);
    tick();
    check("fl_dropped", count, 0);

    // Reset mid-operation
    do_reset();
    in_valid = 1'b1; out_ready = 1'b1; in_opcode = 8'h87;
    for (int i = 0; i < 8; i++) tick();
    out_ready = 1'b0;
    tick();
    check("mr_count", count, 2);
    check("mr_op_count", op_count, 7);
    in_valid = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mr_rst_count", count, 0);
    check("mr_rst_op_count", op_count, 0);
    check("mr_rst_in_ready", in_ready, 1);
    check("mr_rst_out_valid", out_valid, 0);

    // Saturation
    in_valid = 1'b1; out_ready = 1'b1; in_opcode = 8'h2A;
    tick();
    for (int i = 0; i < 65534; i++) tick();
    check("sat_below", op_count, 16'hFFFE);
    tick();
    check("sat_reach", op_count, 16'hFFFF);
    tick();
    check("sat_hold", op_count, 16'hFFFF);
    in_valid = 1'b0;
    tick();
    check("sat_final", op_count, 16'hFFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
